// File: rtl/rv_pkg.sv
// Shared RV32 front-end definitions: reset/NOP constants, fetch FSM states, base opcodes.
package rv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  // addi x0, x0, 0
  localparam logic [31:0] NOP_INS_DEFAULT  = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID
  } fetch_state_e;

  // Base opcodes, shared with the decoder.
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Force an address onto a 32-bit word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_pc_next.sv
// Combinational next-PC selection: flush redirect, taken target or sequential pc+4.
module ifetch_pc_next
  import rv_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        take,
  input  logic [31:0] target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] next_pc,
  output logic [31:0] flush_addr,
  output logic        misalign
);

  // Flush outranks the decoder; low address bits are always dropped.
  always_comb begin
    flush_addr = word_align(flush_pc);
    if (flush) begin
      next_pc = flush_addr;
    end else if (take) begin
      next_pc = word_align(target);
    end else begin
      next_pc = pc + 32'd4;
    end
    misalign = take && (target[1:0] != 2'b00);
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, runs one IMEM read at a time and hands ins/pc/pc4 to
// decode. Optional feature: define IFETCH_MISALIGN_EN to flag misaligned taken targets and park
// the fetch FSM until the next flush.
module ifetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INS  = NOP_INS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  input  logic        pc_sel,
  input  logic [31:0] target,
  input  logic        flush_valid,
`ifdef IFETCH_MISALIGN_EN
  output logic        misalign_err,
`endif
  input  logic [31:0] flush_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ins_q, ins_d;
  // kill: the outstanding response belongs to a fetch superseded by a flush.
  logic         kill_q, kill_d;
  // redir: flush seen while a request waits for grant; applied once the grant lands.
  logic         redir_q, redir_d;
  logic [31:0]  redir_pc_q, redir_pc_d;
`ifdef IFETCH_MISALIGN_EN
  logic         misalign_q, misalign_d;
  logic         park_q, park_d;
`endif

  logic [31:0]  next_pc;
  logic [31:0]  flush_addr;
  logic         tgt_misalign;

  ifetch_pc_next u_pc_next (
    .pc         (pc_q),
    .take       (pc_sel),
    .target     (target),
    .flush      (flush_valid),
    .flush_pc   (flush_pc),
    .next_pc    (next_pc),
    .flush_addr (flush_addr),
    .misalign   (tgt_misalign)
  );

`ifndef IFETCH_MISALIGN_EN
  logic unused_misalign;
  assign unused_misalign = tgt_misalign;
`endif

  // Fetch FSM next-state and PC/instruction update.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ins_d      = ins_q;
    kill_d     = kill_q;
    redir_d    = redir_q;
    redir_pc_d = redir_pc_q;
`ifdef IFETCH_MISALIGN_EN
    misalign_d = misalign_q;
    park_d     = park_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (flush_valid) begin
          pc_d    = flush_addr;
          state_d = S_REQ;
`ifdef IFETCH_MISALIGN_EN
          park_d  = 1'b0;
`endif
        end else begin
`ifdef IFETCH_MISALIGN_EN
          if (!park_q) state_d = S_REQ;
`else
          state_d = S_REQ;
`endif
        end
      end
      S_REQ: begin
        // Address must stay put until granted; a flush only takes effect at the grant.
        if (imem_gnt) begin
          state_d = S_WAIT;
          if (flush_valid || redir_q) begin
            kill_d  = 1'b1;
            pc_d    = flush_valid ? flush_addr : redir_pc_q;
            redir_d = 1'b0;
          end
        end else if (flush_valid) begin
          redir_d    = 1'b1;
          redir_pc_d = flush_addr;
        end
      end
      S_WAIT: begin
        if (flush_valid) pc_d = flush_addr;
        if (imem_rvalid) begin
          kill_d = 1'b0;
          if (flush_valid || kill_q) begin
            state_d = S_REQ;
          end else begin
            ins_d   = imem_rdata;
            state_d = S_VALID;
          end
        end else if (flush_valid) begin
          kill_d = 1'b1;
        end
      end
      S_VALID: begin
        if (flush_valid) begin
          pc_d    = flush_addr;
          state_d = S_REQ;
        end else if (ins_ready) begin
          pc_d    = next_pc;
          state_d = S_REQ;
`ifdef IFETCH_MISALIGN_EN
          if (tgt_misalign) begin
            misalign_d = 1'b1;
            park_d     = 1'b1;
            state_d    = S_IDLE;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ins_q      <= NOP_INS;
      kill_q     <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= RESET_PC;
`ifdef IFETCH_MISALIGN_EN
      misalign_q <= 1'b0;
      park_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ins_q      <= ins_d;
      kill_q     <= kill_d;
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
`ifdef IFETCH_MISALIGN_EN
      misalign_q <= misalign_d;
      park_q     <= park_d;
`endif
    end
  end

  // Outputs are pure functions of registered state.
  always_comb begin
    imem_req  = (state_q == S_REQ);
    imem_addr = pc_q;
    ins_valid = (state_q == S_VALID);
    ins       = ins_valid ? ins_q : NOP_INS;
    pc        = pc_q;
    pc4       = pc_q + 32'd4;
`ifdef IFETCH_MISALIGN_EN
    misalign_err = misalign_q;
`endif
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios followed by randomized traffic,
// checked against an architectural model of the expected PC stream and a model IMEM.
module tb_ifetch_unit;
  import rv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] ins, pc, pc4, target, flush_pc;
  logic        ins_valid, ins_ready, pc_sel, flush_valid;
`ifdef IFETCH_MISALIGN_EN
  logic        misalign_err;
`endif

  always #5 clk = ~clk;

  ifetch_unit #(
    .RESET_PC (RST_PC),
    .NOP_INS  (NOP_INS_DEFAULT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .ins          (ins),
    .ins_valid    (ins_valid),
    .ins_ready    (ins_ready),
    .pc           (pc),
    .pc4          (pc4),
    .pc_sel       (pc_sel),
    .target       (target),
    .flush_valid  (flush_valid),
`ifdef IFETCH_MISALIGN_EN
    .misalign_err (misalign_err),
`endif
    .flush_pc     (flush_pc)
  );

  int checks = 0;
  int errors = 0;

  // Architectural model: address of the next instruction decode should see.
  logic [31:0] exp_pc;
  bit          hold, drop, parked;
  int          since_pres;
  bit          rst_drv;

  // IMEM model state.
  bit          req_seen, pend_rsp, junk_next, rand_lat;
  int          gnt_cnt, rv_cnt, gnt_dly, rv_dly;
  logic [31:0] req_addr, rsp_addr;
  logic [31:0] mem_img [logic [31:0]];
  logic [6:0]  opc_tab [10];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    if (mem_img.exists(a)) return mem_img[a];
    h = (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    return {h[31:7], opc_tab[int'(h[10:7]) % 10]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, check against model, drive IMEM and decoder inputs.
  task automatic step(input bit rdy, input bit sel, input logic [31:0] tgt, input bit fl,
                      input logic [31:0] fpc);
    @(negedge clk);
    since_pres++;
    if (!ins_valid) chk("nop_when_invalid", ins, NOP_INS_DEFAULT);
    chk("no_req_while_valid", 32'(imem_req & ins_valid), 32'd0);
    if (hold) chk("held_valid", 32'(ins_valid), 32'd1);
    if (drop) chk("drop_after_retire_or_flush", 32'(ins_valid), 32'd0);
    if (ins_valid) begin
      chk("pc", pc, exp_pc);
      chk("ins", ins, mem_word(exp_pc));
      chk("pc4", pc4, exp_pc + 32'd4);
      since_pres = 0;
    end
    if (imem_req) begin
      if (!req_seen) chk("req_addr", imem_addr, exp_pc);
      else           chk("req_addr_stable", imem_addr, req_addr);
    end
`ifdef IFETCH_MISALIGN_EN
    chk("misalign_err", 32'(misalign_err), 32'(parked));
`endif
    // IMEM responder
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pend_rsp) begin
      if (rv_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = junk_next ? 32'hDEAD_BEEF : mem_word(rsp_addr);
        junk_next   = 1'b0;
        pend_rsp    = 1'b0;
      end else begin
        rv_cnt--;
      end
    end else if (imem_req) begin
      if (!req_seen) begin
        req_seen = 1'b1;
        req_addr = imem_addr;
        gnt_cnt  = rand_lat ? int'($urandom_range(0, 3)) : gnt_dly;
      end
      if (gnt_cnt == 0) begin
        imem_gnt = 1'b1;
        req_seen = 1'b0;
        pend_rsp = 1'b1;
        rsp_addr = req_addr;
        rv_cnt   = rand_lat ? int'($urandom_range(0, 2)) : rv_dly;
      end else begin
        gnt_cnt--;
      end
    end
    // Decoder-side drive and model update for the coming edge
    rst_n       = rst_drv;
    ins_ready   = rdy;
    pc_sel      = sel;
    target      = tgt;
    flush_valid = fl;
    flush_pc    = fpc;
    drop        = 1'b0;
    if (!rst_drv) begin
      exp_pc      = RST_PC;
      hold        = 1'b0;
      parked      = 1'b0;
      req_seen    = 1'b0;
      pend_rsp    = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
    end else if (fl) begin
      exp_pc = word_align(fpc);
      drop   = ins_valid;
      hold   = 1'b0;
    end else if (ins_valid && rdy) begin
      exp_pc = sel ? word_align(tgt) : exp_pc + 32'd4;
      drop   = 1'b1;
      hold   = 1'b0;
`ifdef IFETCH_MISALIGN_EN
      if (sel && tgt[1:0] != 2'b00) parked = 1'b1;
`endif
    end else begin
      hold = ins_valid;
    end
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic run_until_valid(input string tag);
    int n;
    n = 0;
    idle_step();
    while (!ins_valid && n < 40) begin
      idle_step();
      n++;
    end
    chk({tag, "_valid_timeout"}, 32'(ins_valid), 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    idle_step();
    while (!imem_req && n < 40) begin
      idle_step();
      n++;
    end
    chk({tag, "_req_timeout"}, 32'(imem_req), 32'd1);
  endtask

  initial begin
    opc_tab = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_SYSTEM};
    mem_img[32'h0] = 32'h0050_0093;
    rst_n = 1'b0; rst_drv = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    ins_ready = 1'b0; pc_sel = 1'b0; target = 32'h0; flush_valid = 1'b0; flush_pc = 32'h0;
    exp_pc = RST_PC; hold = 1'b0; drop = 1'b0; parked = 1'b0; since_pres = 0;
    req_seen = 1'b0; pend_rsp = 1'b0; junk_next = 1'b0; rand_lat = 1'b0;
    gnt_cnt = 0; rv_cnt = 0; gnt_dly = 0; rv_dly = 0; req_addr = 0; rsp_addr = 0;

    // 1: reset release, immediate grant, rvalid one cycle later
    idle_step();
    idle_step();
    rst_drv = 1'b1;
    idle_step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(ins_valid), 32'd0);
    chk("rst_ins", ins, NOP_INS_DEFAULT);
    chk("rst_pc", pc, RST_PC);
    idle_step();
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr", imem_addr, 32'h0);
    idle_step();
    chk("t1_wait_no_valid", 32'(ins_valid), 32'd0);
    idle_step();
    chk("t1_valid_cycle3", 32'(ins_valid), 32'd1);
    chk("t1_ins", ins, 32'h0050_0093);
    chk("t1_pc", pc, 32'h0);
    chk("t1_pc4", pc4, 32'h4);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    idle_step();
    chk("t1_next_addr", imem_addr, 32'h4);

    // 2: taken target with misaligned low bits
    run_until_valid("t2");
    step(1'b1, 1'b1, 32'h0000_0102, 1'b0, 32'h0);
    idle_step();
`ifdef IFETCH_MISALIGN_EN
    chk("t2_misalign", 32'(misalign_err), 32'd1);
    chk("t2_parked_no_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      idle_step();
      chk("t2_parked_no_req", 32'(imem_req), 32'd0);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0100);
    idle_step();
`endif
    chk("t2_req", 32'(imem_req), 32'd1);
    chk("t2_addr", imem_addr, 32'h0000_0100);

    // 3: downstream stall for five cycles
    run_until_valid("t3");
    for (int i = 0; i < 5; i++) begin
      idle_step();
      chk("t3_stall_no_req", 32'(imem_req), 32'd0);
      chk("t3_stall_pc", pc, 32'h0000_0100);
    end
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    idle_step();
    chk("t3_req_after_retire", 32'(imem_req), 32'd1);
    chk("t3_addr", imem_addr, 32'h0000_0104);

    // 4: flush while waiting for read data; stale word must never reach decode
    rv_dly = 2;
    run_until_valid("t4");
    junk_next = 1'b1;
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    idle_step();
    chk("t4_req", 32'(imem_req), 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0200);
    chk("t4_in_wait", 32'(imem_req | ins_valid), 32'd0);
    rv_dly = 0;
    wait_req("t4");
    chk("t4_refetch_addr", imem_addr, 32'h0000_0200);
    run_until_valid("t4b");
    chk("t4_pc", pc, 32'h0000_0200);
    chk("t4_ins", ins, mem_word(32'h0000_0200));

    // 5: grant withheld four cycles, flush arrives meanwhile
    gnt_dly = 4;
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0, (i == 1), 32'h0000_0300);
      chk("t5_req_held", 32'(imem_req), 32'd1);
      chk("t5_addr_held", imem_addr, 32'h0000_0204);
    end
    gnt_dly = 0;
    idle_step();
    chk("t5_old_granted", imem_addr, 32'h0000_0204);
    wait_req("t5");
    chk("t5_refetch_addr", imem_addr, 32'h0000_0300);
    run_until_valid("t5");
    chk("t5_pc", pc, 32'h0000_0300);

    // 6: PC wrap, then reset in the middle of a fetch
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFE);
    run_until_valid("t6");
    chk("t6_pc", pc, 32'hFFFF_FFFC);
    chk("t6_pc4_wrap", pc4, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    rv_dly = 3;
    wait_req("t6");
    chk("t6_wrap_addr", imem_addr, 32'h0);
    idle_step();
    rst_drv = 1'b0;
    idle_step();
    idle_step();
    chk("t6_rst_valid", 32'(ins_valid), 32'd0);
    chk("t6_rst_pc", pc, RST_PC);
    chk("t6_rst_req", 32'(imem_req), 32'd0);
    rst_drv = 1'b1;
    rv_dly = 0;

    // Randomized traffic
    rand_lat = 1'b1;
    since_pres = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] t;
      t = $urandom;
`ifdef IFETCH_MISALIGN_EN
      t = word_align(t);
`endif
      step($urandom_range(0, 99) < 60, 1'($urandom), t,
           $urandom_range(0, 29) == 0, $urandom);
      if (since_pres > 200) begin
        chk("random_stall_bound", 32'(since_pres), 32'd0);
        break;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
